// File: rtl/alu_op_seq.sv
// ============================================================================
// Module      : alu_op_seq
// Description : Operation sequencer feeding a 2-bit ALU. Registers one op per
//               handshake onto the ALU pins, captures its 4-bit result and
//               presents it downstream. Supports chaining a from the last result.
//               Optional macro ALU_SEQ_ILLEGAL_ERR_EN adds the op_err output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    input  logic [3:0]       in_select,
    input  logic             in_c_in,
    input  logic             in_chain,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    output logic             alu_c_in,
    output logic [3:0]       alu_select,
    input  logic [3:0]       alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_y,
    output logic             out_zero,
`ifdef ALU_SEQ_ILLEGAL_ERR_EN
    output logic             op_err,
`endif
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] r_state;
    // Only the low two bits of the previous result can ever feed a chained op.
    logic [1:0] r_last_y;

    assign in_ready = (r_state == IDLE);

`ifdef ALU_SEQ_ILLEGAL_ERR_EN
    logic w_illegal;

    always_comb begin
        w_illegal = 1'b1;
        case (alu_select)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b0111:           w_illegal = 1'b0;
            4'b0100, 4'b0110, 4'b1000:  w_illegal = alu_c_in;
            default:                    w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_err <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            op_err <= 1'b0;
        end else if (r_state == EXEC) begin
            op_err <= w_illegal;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            alu_a      <= 2'b00;
            alu_b      <= 2'b00;
            alu_select <= 4'b0000;
            alu_c_in   <= 1'b0;
            out_y      <= 4'b0000;
            out_zero   <= 1'b1;
            out_valid  <= 1'b0;
            op_cnt     <= '0;
            r_last_y   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a      <= in_chain ? r_last_y : in_a;
                        alu_b      <= in_b;
                        alu_select <= in_select;
                        alu_c_in   <= in_c_in;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    out_y     <= alu_y;
                    out_zero  <= (alu_y == 4'b0000);
                    r_last_y  <= alu_y[1:0];
                    out_valid <= 1'b1;
                    r_state   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_cnt    <= op_cnt + 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
